// File: rtl/crossbar_mcast_rr_if.sv
// Handshake bundle for the multicast crossbar: source side (valid/data/dest/ready_o)
// and sink side (valid_o/data_o/ready_i), plus the source hold-stable protocol check.
interface crossbar_mcast_rr_if #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst
);
  logic [PORTS-1:0]            valid_i;
  logic [PORTS-1:0][WIDTH-1:0] data_i;
  logic [PORTS-1:0][PORTS-1:0] dest;
  logic [PORTS-1:0]            ready_o;
  logic [PORTS-1:0]            valid_o;
  logic [PORTS-1:0][WIDTH-1:0] data_o;
  logic [PORTS-1:0]            ready_i;

  modport slave (
    input  valid_i, data_i, dest, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, dest, ready_i,
    input  ready_o, valid_o, data_o
  );

  // A pending word may be withdrawn, but never altered, until it is retired
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_hold_chk
    a_word_stable: assert property (@(posedge clk) disable iff (rst)
      (valid_i[gi] && !ready_o[gi]) |=>
        (!valid_i[gi] || ($stable(data_i[gi]) && $stable(dest[gi]))));
  end
endinterface

// File: rtl/crossbar_mcast_rr.sv
// Registered multicast crossbar: per-output round-robin arbitration, a word is
// retired only once every destination in its mask has taken it.
module crossbar_mcast_rr #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  crossbar_mcast_rr_if.slave io_xbar
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0]            r_valid_o;
  logic [PORTS-1:0][WIDTH-1:0] r_data_o;
  logic [PORTS-1:0][PORTS-1:0] r_served;
  logic [PORTS-1:0][PW-1:0]    r_rr_ptr;

  logic [PORTS-1:0][PORTS-1:0] w_req;        // [input][output]
  logic [PORTS-1:0]            w_load_ok;
  logic [PORTS-1:0][PORTS-1:0] w_grant;      // [output][input]
  logic [PORTS-1:0][PORTS-1:0] w_grant_mask; // [input][output]
  logic [PORTS-1:0]            w_grant_any;
  logic [PORTS-1:0][PW-1:0]    w_grant_idx;
  logic [PORTS-1:0][PW-1:0]    w_ptr_nxt;
  logic [PORTS-1:0]            w_done;

  function automatic int wrap_idx(input logic [PW-1:0] ptr, input int k);
    return (int'(ptr) + k) % PORTS;
  endfunction

  // Outstanding requests exclude destinations already served for this word
  always_comb begin
    w_req     = '0;
    w_load_ok = ~r_valid_o | io_xbar.ready_i;
    for (int i = 0; i < PORTS; i++) begin
      w_req[i] = {PORTS{io_xbar.valid_i[i]}} & io_xbar.dest[i] & ~r_served[i];
    end
  end

  // Round-robin search per output, starting at its pointer and wrapping
  always_comb begin
    w_grant     = '0;
    w_grant_any = '0;
    w_grant_idx = '0;
    w_ptr_nxt   = r_rr_ptr;
    for (int j = 0; j < PORTS; j++) begin
      for (int k = 0; k < PORTS; k++) begin
        if (!w_grant_any[j] && w_load_ok[j] && w_req[wrap_idx(r_rr_ptr[j], k)][j]) begin
          w_grant[j][wrap_idx(r_rr_ptr[j], k)] = 1'b1;
          w_grant_any[j]                       = 1'b1;
          w_grant_idx[j]                       = PW'(wrap_idx(r_rr_ptr[j], k));
          w_ptr_nxt[j]                         = PW'(wrap_idx(r_rr_ptr[j], k + 1));
        end else begin
          w_grant_any[j] = w_grant_any[j];
        end
      end
    end
  end

  // Retire when served plus this cycle's grants cover the whole mask
  always_comb begin
    w_grant_mask = '0;
    w_done       = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = 0; j < PORTS; j++) begin
        w_grant_mask[i][j] = w_grant[j][i];
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      w_done[i] = io_xbar.valid_i[i] &
                  (((r_served[i] | w_grant_mask[i]) & io_xbar.dest[i]) == io_xbar.dest[i]);
    end
  end

  assign io_xbar.ready_o = rst ? {PORTS{1'b0}} : w_done;
  assign io_xbar.valid_o = r_valid_o;
  assign io_xbar.data_o  = r_data_o;

  // Output slots, served masks and arbitration pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_o <= '0;
      r_data_o  <= '0;
      r_served  <= '0;
      r_rr_ptr  <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if (w_grant_any[j]) begin
          r_data_o[j]  <= io_xbar.data_i[w_grant_idx[j]];
          r_valid_o[j] <= 1'b1;
          r_rr_ptr[j]  <= w_ptr_nxt[j];
        end else if (io_xbar.ready_i[j]) begin
          r_valid_o[j] <= 1'b0;
        end
      end
      for (int i = 0; i < PORTS; i++) begin
        if (w_done[i]) begin
          r_served[i] <= '0;
        end else begin
          r_served[i] <= r_served[i] | w_grant_mask[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_crossbar_mcast_rr.sv
// Directed bench for crossbar_mcast_rr: inputs change #1 after posedge, ready_o is
// sampled on the negedge, registered outputs #1 after the loading edge.
module tb_crossbar_mcast_rr;
  localparam int PORTS = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  crossbar_mcast_rr_if #(.PORTS(PORTS), .WIDTH(WIDTH)) xif (.clk(clk), .rst(rst));

  crossbar_mcast_rr #(.PORTS(PORTS), .WIDTH(WIDTH)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .io_xbar (xif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    xif.valid_i = 4'b0000;
    xif.data_i  = 32'h0;
    xif.dest    = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    xif.ready_i = 4'b1111;
    tick();
    total++;
    if (xif.valid_o !== 4'b0000) begin
      bad++; $display("FAIL reset_valid got=%b exp=0000", xif.valid_o);
    end
    total++;
    if (xif.data_o !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=00000000", xif.data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_unicast();
    xif.ready_i   = 4'b1111;
    xif.valid_i   = 4'b0001;
    xif.data_i[0] = 8'hA5;
    xif.dest[0]   = 4'b0010;
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0001) begin
      bad++; $display("FAIL uni_ready got=%b exp=0001", xif.ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (xif.valid_o !== 4'b0010) begin
      bad++; $display("FAIL uni_valid got=%b exp=0010", xif.valid_o);
    end
    total++;
    if (xif.data_o[1] !== 8'hA5) begin
      bad++; $display("FAIL uni_data got=%h exp=a5", xif.data_o[1]);
    end
    tick();
    total++;
    if (xif.valid_o !== 4'b0000) begin
      bad++; $display("FAIL uni_drain got=%b exp=0000", xif.valid_o);
    end
  endtask

  task automatic test_multicast();
    xif.ready_i   = 4'b1111;
    xif.valid_i   = 4'b0100;
    xif.data_i[2] = 8'h3C;
    xif.dest[2]   = 4'b1111;
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0100) begin
      bad++; $display("FAIL mc_ready got=%b exp=0100", xif.ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (xif.valid_o !== 4'b1111) begin
      bad++; $display("FAIL mc_valid got=%b exp=1111", xif.valid_o);
    end
    total++;
    if (xif.data_o !== {4{8'h3C}}) begin
      bad++; $display("FAIL mc_data got=%h exp=3c3c3c3c", xif.data_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy [6];
    logic [7:0] exp_dat [6];
    exp_rdy = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    exp_dat = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
    xif.ready_i   = 4'b1111;
    xif.valid_i   = 4'b1011;
    xif.data_i[0] = 8'h10;
    xif.data_i[1] = 8'h11;
    xif.data_i[3] = 8'h13;
    xif.dest[0]   = 4'b0100;
    xif.dest[1]   = 4'b0100;
    xif.dest[3]   = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (xif.ready_o !== exp_rdy[k]) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, xif.ready_o, exp_rdy[k]);
      end
      tick();
      total++;
      if (xif.valid_o[2] !== 1'b1 || xif.data_o[2] !== exp_dat[k]) begin
        bad++; $display("FAIL rr_out2[%0d] got=%b/%h exp=1/%h", k, xif.valid_o[2], xif.data_o[2], exp_dat[k]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    xif.ready_i   = 4'b1011;
    xif.valid_i   = 4'b1000;
    xif.data_i[3] = 8'h99;
    xif.dest[3]   = 4'b0100;
    tick();
    idle_inputs();
    xif.valid_i   = 4'b0010;
    xif.data_i[1] = 8'h77;
    xif.dest[1]   = 4'b0101;
    total++;
    if (xif.valid_o !== 4'b0100 || xif.data_o[2] !== 8'h99) begin
      bad++; $display("FAIL bp_preload got=%b/%h exp=0100/99", xif.valid_o, xif.data_o[2]);
    end
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0000) begin
      bad++; $display("FAIL bp_partial_ready got=%b exp=0000", xif.ready_o);
    end
    tick();
    total++;
    if (xif.valid_o !== 4'b0101 || xif.data_o[0] !== 8'h77 || xif.data_o[2] !== 8'h99) begin
      bad++; $display("FAIL bp_out0 got=%b/%h/%h exp=0101/77/99", xif.valid_o, xif.data_o[0], xif.data_o[2]);
    end
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0000) begin
      bad++; $display("FAIL bp_still_blocked got=%b exp=0000", xif.ready_o);
    end
    tick();
    total++;
    if (xif.valid_o !== 4'b0100) begin
      bad++; $display("FAIL bp_no_resend got=%b exp=0100", xif.valid_o);
    end
    xif.ready_i = 4'b1111;
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0010) begin
      bad++; $display("FAIL bp_final_ready got=%b exp=0010", xif.ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (xif.valid_o !== 4'b0100 || xif.data_o[2] !== 8'h77) begin
      bad++; $display("FAIL bp_out2 got=%b/%h exp=0100/77", xif.valid_o, xif.data_o[2]);
    end
  endtask

  task automatic test_zero_dest();
    xif.ready_i   = 4'b0000;
    xif.valid_i   = 4'b1000;
    xif.data_i[3] = 8'hAB;
    xif.dest[3]   = 4'b0000;
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b1000) begin
      bad++; $display("FAIL zd_ready got=%b exp=1000", xif.ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (xif.valid_o !== 4'b0100) begin
      bad++; $display("FAIL zd_valid got=%b exp=0100", xif.valid_o);
    end
    total++;
    if (xif.data_o !== 32'h0077_0077) begin
      bad++; $display("FAIL zd_data got=%h exp=00770077", xif.data_o);
    end
    xif.ready_i = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    xif.ready_i   = 4'b1011;
    xif.valid_i   = 4'b1000;
    xif.data_i[3] = 8'h99;
    xif.dest[3]   = 4'b0100;
    tick();
    idle_inputs();
    xif.valid_i   = 4'b0010;
    xif.data_i[1] = 8'h77;
    xif.dest[1]   = 4'b0101;
    tick();
    total++;
    if (xif.valid_o !== 4'b0101) begin
      bad++; $display("FAIL rmw_partial got=%b exp=0101", xif.valid_o);
    end
    rst = 1'b1;
    xif.ready_i = 4'b1111;
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0000) begin
      bad++; $display("FAIL rmw_ready_in_rst got=%b exp=0000", xif.ready_o);
    end
    tick();
    rst = 1'b0;
    total++;
    if (xif.valid_o !== 4'b0000 || xif.data_o !== 32'h0) begin
      bad++; $display("FAIL rmw_cleared got=%b/%h exp=0000/00000000", xif.valid_o, xif.data_o);
    end
    @(negedge clk);
    total++;
    if (xif.ready_o !== 4'b0010) begin
      bad++; $display("FAIL rmw_replay_ready got=%b exp=0010", xif.ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (xif.valid_o !== 4'b0101 || xif.data_o !== 32'h0077_0077) begin
      bad++; $display("FAIL rmw_replay_out got=%b/%h exp=0101/00770077", xif.valid_o, xif.data_o);
    end
  endtask

  initial begin
    idle_inputs();
    xif.ready_i = 4'b1111;
    test_reset();
    test_unicast();
    test_multicast();
    do_reset();
    test_round_robin();
    test_backpressure();
    test_zero_dest();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
